// File: rtl/simple_bus_pkg.sv
// Shared types and constants for the simple bus command executor.
// Holds the opcode and FSM state encodings plus a legality helper.
package simple_bus_pkg;

    localparam int ACC_W = 16;

    typedef enum logic [3:0] {
        CMD_NOP  = 4'd0,
        CMD_LOAD = 4'd1,
        CMD_ADD  = 4'd2,
        CMD_SUB  = 4'd3,
        CMD_AND  = 4'd4,
        CMD_OR   = 4'd5,
        CMD_XOR  = 4'd6,
        CMD_SHL  = 4'd7,
        CMD_CLR  = 4'd8,
        CMD_WAIT = 4'd9
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Opcodes 10..15 have no defined operation.
    function automatic logic cmd_is_legal(input logic [3:0] cmd);
        return (cmd <= 4'd9);
    endfunction

endpackage

// File: rtl/simple_bus_alu.sv
// Combinational next-accumulator computation for one opcode.
// Arithmetic is modulo 2^ACC_W; NOP, WAIT and illegal opcodes pass acc through.
module simple_bus_alu
    import simple_bus_pkg::*;
(
    input  logic [3:0]       cmd_i,
    input  logic [ACC_W-1:0] acc_i,
    input  logic [ACC_W-1:0] saddr_i,
    output logic [ACC_W-1:0] acc_o
);

    // Opcode decode to the next accumulator value.
    always_comb begin
        acc_o = acc_i;
        case (cmd_i)
            CMD_LOAD: acc_o = saddr_i;
            CMD_ADD:  acc_o = acc_i + saddr_i;
            CMD_SUB:  acc_o = acc_i - saddr_i;
            CMD_AND:  acc_o = acc_i & saddr_i;
            CMD_OR:   acc_o = acc_i | saddr_i;
            CMD_XOR:  acc_o = acc_i ^ saddr_i;
            CMD_SHL:  acc_o = acc_i << saddr_i[3:0];
            CMD_CLR:  acc_o = {ACC_W{1'b0}};
            default:  acc_o = acc_i;
        endcase
    end

endmodule

// File: rtl/simple_bus_exec.sv
// Single-command executor: accepts a command in IDLE, applies it to acc,
// optionally waits n cycles, then pulses done (and err for illegal opcodes).
module simple_bus_exec
    import simple_bus_pkg::*;
#(
    parameter int WAIT_W = 8
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             en,
    input  logic [3:0]       cmd,
    input  logic [ACC_W-1:0] saddr,
    output logic             done,
    output logic             err,
    output logic             busy,
    output logic [ACC_W-1:0] acc,
    output logic             ovr
);

    state_e              state_q, state_d;
    logic [3:0]          cmd_q, cmd_d;
    logic [ACC_W-1:0]    saddr_q, saddr_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [WAIT_W-1:0]   cnt_q, cnt_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic                ovr_q, ovr_d;
    logic [ACC_W-1:0]    alu_acc_s;
    logic [WAIT_W-1:0]   wait_n_s;

    simple_bus_alu u_alu (
        .cmd_i   (cmd_q),
        .acc_i   (acc_q),
        .saddr_i (saddr_q),
        .acc_o   (alu_acc_s)
    );

    assign wait_n_s = saddr_q[WAIT_W-1:0];

    // Next-state, operand capture, accumulator update and output decode.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        saddr_d = saddr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_EXEC;
                    cmd_d   = cmd;
                    saddr_d = saddr;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                acc_d = alu_acc_s;
                if ((cmd_q == CMD_WAIT) && (wait_n_s != {WAIT_W{1'b0}})) begin
                    state_d = ST_WAIT;
                    cnt_d   = wait_n_s;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_WAIT: begin
                // The EXEC edge already consumed one of the n cycles' worth of lead-in,
                // so leave when the count reaches one.
                if (cnt_q <= {{(WAIT_W-1){1'b0}}, 1'b1}) begin
                    state_d = ST_DONE;
                    cnt_d   = {WAIT_W{1'b0}};
                end else begin
                    cnt_d   = cnt_q - {{(WAIT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        done_d = (state_q == ST_DONE);
        err_d  = (state_q == ST_DONE) && !cmd_is_legal(cmd_q);
        busy_d = (state_d != ST_IDLE);
        ovr_d  = ovr_q | (en && (state_q != ST_IDLE));
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            state_q <= ST_IDLE;
            cmd_q   <= 4'd0;
            saddr_q <= {ACC_W{1'b0}};
            acc_q   <= {ACC_W{1'b0}};
            cnt_q   <= {WAIT_W{1'b0}};
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            saddr_q <= saddr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
        end
    end

    assign done = done_q;
    assign err  = err_q;
    assign busy = busy_q;
    assign acc  = acc_q;
    assign ovr  = ovr_q;

endmodule

// File: tb/tb_simple_bus_exec.sv
// Self-checking bench: directed sequences plus random traffic, checked every
// cycle against a timeline model (accept edge, acc-update edge, done edge).
module tb_simple_bus_exec;

    logic        clk = 1'b0;
    logic        rst_ = 1'b0;
    logic        en = 1'b0;
    logic [3:0]  cmd = 4'd0;
    logic [15:0] saddr = 16'd0;
    logic        done, err, busy, ovr;
    logic [15:0] acc;

    int n_vec = 0;
    int n_bad = 0;
    int k = 0;

    int m_acc = 0, m_pend_acc = 0, m_pend_at = -1;
    int m_start_at = -1, m_done_at = -1, m_accept_from = 0;
    bit m_ovr = 1'b0, m_illegal = 1'b0;

    simple_bus_exec #(.WAIT_W(8)) dut (
        .clk   (clk),
        .rst_  (rst_),
        .en    (en),
        .cmd   (cmd),
        .saddr (saddr),
        .done  (done),
        .err   (err),
        .busy  (busy),
        .acc   (acc),
        .ovr   (ovr)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input int exp);
        n_vec++;
        if (got !== 32'(exp)) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, k);
        end
    endtask

    function automatic int ref_alu(input int c, input int a, input int s);
        case (c)
            1:       return s;
            2:       return (a + s) % 65536;
            3:       return (a - s + 65536) % 65536;
            4:       return a & s;
            5:       return a | s;
            6:       return a ^ s;
            7:       return (a * (1 << (s % 16))) % 65536;
            8:       return 0;
            default: return a;
        endcase
    endfunction

    task automatic model_edge(input bit r, input bit e, input int c, input int s);
        int n;
        if (!r) begin
            m_acc = 0; m_pend_at = -1; m_start_at = -1; m_done_at = -1;
            m_ovr = 1'b0; m_illegal = 1'b0; m_accept_from = k + 1;
        end else begin
            if (m_pend_at == k) m_acc = m_pend_acc;
            if (e) begin
                if (k >= m_accept_from) begin
                    n = (c == 9) ? (s % 256) : 0;
                    m_start_at    = k;
                    m_pend_at     = k + 1;
                    m_pend_acc    = ref_alu(c, m_acc, s);
                    m_done_at     = k + 2 + n;
                    m_accept_from = m_done_at + 1;
                    m_illegal     = (c > 9);
                end else begin
                    m_ovr = 1'b1;
                end
            end
        end
    endtask

    task automatic step(input bit r, input bit e, input logic [3:0] c, input logic [15:0] s);
        bit exp_done;
        @(negedge clk);
        rst_ = r; en = e; cmd = c; saddr = s;
        @(posedge clk);
        model_edge(r, e, int'(c), int'(s));
        #1;
        exp_done = (k == m_done_at);
        check_eq("done", 32'(done), int'(exp_done));
        check_eq("err", 32'(err), int'(exp_done && m_illegal));
        check_eq("busy", 32'(busy), int'(m_start_at >= 0 && k >= m_start_at && k < m_done_at));
        check_eq("acc", 32'(acc), m_acc);
        check_eq("ovr", 32'(ovr), int'(m_ovr));
        k++;
    endtask

    task automatic run_cmd(input logic [3:0] c, input logic [15:0] s, input int idle_after);
        step(1'b1, 1'b1, c, s);
        repeat (idle_after) step(1'b1, 1'b0, 4'd0, 16'd0);
    endtask

    initial begin
        logic [3:0]  rc;
        logic [15:0] rs;
        step(1'b0, 1'b0, 4'd0, 16'd0);
        step(1'b0, 1'b1, 4'd1, 16'hBEEF);

        run_cmd(4'd1, 16'h1234, 2);
        run_cmd(4'd2, 16'h0F00, 2);
        check_eq("acc_load_add", 32'(acc), 16'h2134);

        run_cmd(4'd1, 16'hFFFF, 2);
        run_cmd(4'd2, 16'h0002, 2);
        check_eq("acc_add_wrap", 32'(acc), 16'h0001);
        run_cmd(4'd3, 16'h0002, 2);
        check_eq("acc_sub_wrap", 32'(acc), 16'hFFFF);
        run_cmd(4'd7, 16'h0004, 2);
        check_eq("acc_shl", 32'(acc), 16'hFFF0);

        run_cmd(4'd9, 16'h0005, 7);
        run_cmd(4'd9, 16'h0000, 2);
        run_cmd(4'hB, 16'h1234, 2);
        check_eq("acc_illegal", 32'(acc), 16'hFFF0);
        run_cmd(4'd0, 16'h5555, 2);

        // en held high across a whole ADD: only the first strobe executes.
        repeat (3) step(1'b1, 1'b1, 4'd2, 16'h0001);
        step(1'b1, 1'b0, 4'd0, 16'd0);
        check_eq("acc_single_add", 32'(acc), 16'hFFF1);
        check_eq("ovr_sticky", 32'(ovr), 1);
        repeat (4) step(1'b1, 1'b0, 4'd0, 16'd0);

        // Reset in the middle of a long WAIT aborts it.
        run_cmd(4'd1, 16'h0055, 2);
        run_cmd(4'd9, 16'h000A, 4);
        step(1'b0, 1'b0, 4'd0, 16'd0);
        check_eq("acc_after_abort", 32'(acc), 0);
        check_eq("busy_after_abort", 32'(busy), 0);
        repeat (12) step(1'b1, 1'b0, 4'd0, 16'd0);
        run_cmd(4'd1, 16'h00AB, 2);
        check_eq("acc_post_reset_load", 32'(acc), 16'h00AB);

        for (int i = 0; i < 600; i++) begin
            rc = 4'($urandom_range(0, 15));
            rs = 16'($urandom);
            if (rc == 4'd9) rs = rs & 16'h000F;
            step(($urandom_range(0, 59) != 0), ($urandom_range(0, 2) == 0), rc, rs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
